mem_wb_stage: RTL and testbench

Pipeline register and load-formatting stage between MEM and the general register file (GPR): latches the MEM-stage result, formats synchronous data-RAM read data for LB/LBU/LH/LHU/LW/LWL/LWR, and drives the GPR write port (waddr/wdata/we). It handles stall/flush bubbles and captures one-cycle RAM read data across WB stalls. Its outputs also feed the GPR same-cycle write-to-read bypass, so write-back data is zero-qualified.

---
 rtl/mem_wb_stage_if.sv | 27 ++
 rtl/mem_wb_stage.sv | 97 +++++++++
 tb/tb_mem_wb_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bus: MEM-stage result, data-RAM read word, pipeline control and GPR write port.
interface mem_wb_stage_if;
   logic        mem_we;
   logic [4:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_load_op;
   logic [1:0]  mem_addr_lo;
   logic [31:0] dram_rdata;
   logic        stall_mem;
   logic        stall_wb;
   logic        flush;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;

   modport master (
      output mem_we, mem_waddr, mem_wdata, mem_load_op, mem_addr_lo,
      output dram_rdata, stall_mem, stall_wb, flush,
      input  wb_we, wb_waddr, wb_wdata
   );

   modport slave (
      input  mem_we, mem_waddr, mem_wdata, mem_load_op, mem_addr_lo,
      input  dram_rdata, stall_mem, stall_wb, flush,
      output wb_we, wb_waddr, wb_wdata
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatting; drives a zero-qualified GPR write port.
module mem_wb_stage (
   input logic           clk,
   input logic           rst,
   mem_wb_stage_if.slave bus
);
   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_LB   = 3'd1,
      OP_LBU  = 3'd2,
      OP_LH   = 3'd3,
      OP_LHU  = 3'd4,
      OP_LW   = 3'd5,
      OP_LWL  = 3'd6,
      OP_LWR  = 3'd7
   } load_op_e;

   logic        we_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;
   load_op_e    op_q;
   logic [1:0]  lo_q;
   logic        first_q;
   logic        held_q;
   logic [31:0] hold_q;

   logic [31:0] rw;
   logic [7:0]  rb;
   logic [15:0] rh;
   logic [31:0] r;
   logic        we_eff;

   always_ff @(posedge clk) begin
      if (rst || bus.flush || (bus.stall_mem && !bus.stall_wb)) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         op_q    <= OP_NONE;
         lo_q    <= '0;
         first_q <= 1'b0;
         held_q  <= 1'b0;
      end else if (!bus.stall_mem) begin
         we_q    <= bus.mem_we;
         waddr_q <= bus.mem_waddr;
         wdata_q <= bus.mem_wdata;
         op_q    <= load_op_e'(bus.mem_load_op);
         lo_q    <= bus.mem_addr_lo;
         first_q <= 1'b1;
         held_q  <= 1'b0;
      end else begin
         // RAM word is only valid in the first WB cycle; keep a copy for the rest of the stall
         if (first_q && (op_q != OP_NONE)) begin
            hold_q <= bus.dram_rdata;
            held_q <= 1'b1;
         end
         first_q <= 1'b0;
      end
   end

   always_comb begin
      rw = held_q ? hold_q : bus.dram_rdata;
      rb = rw[{lo_q, 3'b000} +: 8];
      rh = lo_q[1] ? rw[31:16] : rw[15:0];
      r  = wdata_q;
      unique case (op_q)
         OP_NONE: r = wdata_q;
         OP_LB:   r = {{24{rb[7]}}, rb};
         OP_LBU:  r = {24'h000000, rb};
         OP_LH:   r = {{16{rh[15]}}, rh};
         OP_LHU:  r = {16'h0000, rh};
         OP_LW:   r = rw;
         OP_LWL: begin
            case (lo_q)
               2'd0:    r = {rw[7:0],  wdata_q[23:0]};
               2'd1:    r = {rw[15:0], wdata_q[15:0]};
               2'd2:    r = {rw[23:0], wdata_q[7:0]};
               default: r = rw;
            endcase
         end
         OP_LWR: begin
            case (lo_q)
               2'd0:    r = rw;
               2'd1:    r = {wdata_q[31:24], rw[31:8]};
               2'd2:    r = {wdata_q[31:16], rw[31:16]};
               default: r = {wdata_q[31:8],  rw[31:24]};
            endcase
         end
         default: r = wdata_q;
      endcase
   end

   // GPR bypass matches on address alone, so idle slots must present address 0 and data 0
   assign we_eff       = we_q && (waddr_q != '0);
   assign bus.wb_we    = we_eff;
   assign bus.wb_waddr = we_eff ? waddr_q : '0;
   assign bus.wb_wdata = we_eff ? r : '0;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected GPR writes queued at drive time, compared in the WB cycle.
module tb_mem_wb_stage;
   logic clk;
   logic rst;
   mem_wb_stage_if bus ();

   mem_wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   exp_t last_exp = '0;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      else
         n_pass++;
   endtask

   // Reference formatting written with shifts/masks rather than per-lane selects
   function automatic logic [31:0] ref_fmt(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] rt, input logic [31:0] rw);
      int unsigned sb_amt;
      int unsigned sh_amt;
      logic [31:0] bsh;
      logic [31:0] hsh;
      sb_amt = 8 * int'(lo);
      sh_amt = 16 * int'(lo[1]);
      bsh = rw >> sb_amt;
      hsh = rw >> sh_amt;
      case (op)
         3'd1:    return {{24{bsh[7]}}, bsh[7:0]};
         3'd2:    return {24'h0, bsh[7:0]};
         3'd3:    return {{16{hsh[15]}}, hsh[15:0]};
         3'd4:    return {16'h0, hsh[15:0]};
         3'd5:    return rw;
         3'd6:    return (rw << (24 - sb_amt)) | (rt & (32'h00FFFFFF >> sb_amt));
         3'd7:    return (rw >> sb_amt) | (rt & ~(32'hFFFFFFFF >> sb_amt));
         default: return rt;
      endcase
   endfunction

   // One clock: drive controls/MEM inputs, queue the expected WB contents, then present
   // rd as the RAM word during the WB cycle and compare at the negedge.
   task automatic cyc(input string tag, input logic r, input logic f, input logic sm, input logic sw,
                      input logic mwe, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rd);
      exp_t e;
      exp_t got;
      rst                 = r;
      bus.flush           = f;
      bus.stall_mem       = sm;
      bus.stall_wb        = sw;
      bus.mem_we          = mwe;
      bus.mem_waddr       = wa;
      bus.mem_wdata       = wd;
      bus.mem_load_op     = op;
      bus.mem_addr_lo     = lo;
      if (r || f || (sm && !sw)) begin
         e = '0;
      end else if (!sm) begin
         e.we    = mwe && (wa != 5'd0);
         e.waddr = e.we ? wa : 5'd0;
         e.wdata = e.we ? ref_fmt(op, lo, wd, rd) : 32'h0;
      end else begin
         e = last_exp;
      end
      last_exp = e;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.dram_rdata = rd;
      @(negedge clk);
      got = sb.pop_front();
      check({tag, ".we"},    {31'h0, bus.wb_we},    {31'h0, got.we});
      check({tag, ".waddr"}, {27'h0, bus.wb_waddr}, {27'h0, got.waddr});
      check({tag, ".wdata"}, bus.wb_wdata,          got.wdata);
   endtask

   initial begin
      bus.dram_rdata = 32'h0;
      // Reset held two cycles with a valid write on the inputs
      cyc("rst0", 1, 0, 0, 0, 1, 5, 32'h0000_0055, 0, 0, 32'h0);
      check("rst0.const_we", {31'h0, bus.wb_we}, 32'h0);
      cyc("rst1", 1, 0, 0, 0, 1, 5, 32'h0000_0055, 0, 0, 32'h0);
      cyc("post_rst", 0, 0, 0, 0, 1, 5, 32'h0000_A5A5, 0, 0, 32'h0);
      check("post_rst.const_waddr", {27'h0, bus.wb_waddr}, 32'd5);

      // Load formatting
      cyc("lb3",  0, 0, 0, 0, 1, 1, 32'h0, 3'd1, 2'd3, 32'h8091A2B3);
      check("lb3.const", bus.wb_wdata, 32'hFFFFFF80);
      cyc("lbu0", 0, 0, 0, 0, 1, 2, 32'h0, 3'd2, 2'd0, 32'h8091A2B3);
      cyc("lh2",  0, 0, 0, 0, 1, 3, 32'h0, 3'd3, 2'd2, 32'h8091A2B3);
      check("lh2.const", bus.wb_wdata, 32'hFFFF8091);
      cyc("lhu0", 0, 0, 0, 0, 1, 4, 32'h0, 3'd4, 2'd0, 32'h8091A2B3);
      cyc("lw",   0, 0, 0, 0, 1, 6, 32'h0, 3'd5, 2'd0, 32'h8091A2B3);
      cyc("lwl1", 0, 0, 0, 0, 1, 9, 32'h11223344, 3'd6, 2'd1, 32'hAABBCCDD);
      check("lwl1.const", bus.wb_wdata, 32'hCCDD3344);
      cyc("lwr2", 0, 0, 0, 0, 1, 9, 32'h11223344, 3'd7, 2'd2, 32'hAABBCCDD);
      check("lwr2.const", bus.wb_wdata, 32'h1122AABB);

      // WB stall on a load: RAM word changes, output must keep the original
      cyc("lw_st", 0, 0, 0, 0, 1, 7, 32'h0, 3'd5, 2'd0, 32'hCAFEF00D);
      for (int i = 0; i < 3; i++)
         cyc("lw_hold", 0, 0, 1, 1, 1, 12, 32'h0, 3'd5, 2'd0, 32'hDEADBEEF);
      check("lw_hold.const", bus.wb_wdata, 32'hCAFEF00D);
      cyc("after_hold", 0, 0, 0, 0, 1, 8, 32'h0, 3'd1, 2'd0, 32'h0000007F);

      // Bubbles and flush
      cyc("bubble", 0, 0, 1, 0, 1, 10, 32'h1111, 3'd0, 2'd0, 32'h0);
      cyc("flush",  0, 1, 0, 0, 1, 11, 32'h2222, 3'd0, 2'd0, 32'h0);
      cyc("lw_f",   0, 0, 0, 0, 1, 13, 32'h0, 3'd5, 2'd0, 32'h01020304);
      cyc("lw_f_h", 0, 0, 1, 1, 1, 13, 32'h0, 3'd5, 2'd0, 32'h55555555);
      cyc("flush_h",0, 1, 1, 1, 1, 13, 32'h0, 3'd5, 2'd0, 32'h0);
      cyc("lw_new", 0, 0, 0, 0, 1, 14, 32'h0, 3'd5, 2'd0, 32'h0A0B0C0D);

      // r0 write and a held non-load instruction
      cyc("r0",     0, 0, 0, 0, 1, 0, 32'h12345678, 3'd0, 2'd0, 32'h0);
      cyc("alu",    0, 0, 0, 0, 1, 15, 32'h600DF00D, 3'd0, 2'd0, 32'h0);
      cyc("alu_h",  0, 0, 1, 1, 1, 16, 32'h0, 3'd0, 2'd0, 32'hFFFFFFFF);

      // Random mix of captures, bubbles, holds and flushes
      for (int i = 0; i < 60; i++) begin
         int unsigned k;
         k = $urandom_range(0, 9);
         case (k)
            0:       cyc("rnd_bub",  0, 0, 1, 0, 1, 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
            1, 2:    cyc("rnd_hold", 0, 0, 1, 1, 1, 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
            3:       cyc("rnd_fl",   0, 1, 0, 0, 1, 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
            default: cyc("rnd_cap",  0, 0, 0, 0, 1'($urandom), 5'($urandom), $urandom, 3'($urandom), 2'($urandom), $urandom);
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
